// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_pkg
// Description : Shared widths, fetch FSM state encodings, reset instruction
//               value and alignment helper for the instruction fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_fetch_pkg;

    localparam int ADDR_LEN = 32;
    localparam int INST_LEN = 32;

    // Value presented on inst while nothing has been fetched yet.
    localparam logic [INST_LEN-1:0] INST_RESET = '0;

    typedef enum logic [1:0] {
        IF_IDLE = 2'b00,
        IF_WAIT = 2'b01,
        IF_HOLD = 2'b10,
        IF_ERR  = 2'b11
    } if_state_e;

    // True when the address is on a 32-bit word boundary.
    function automatic logic is_word_aligned(input logic [ADDR_LEN-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage : instr_fetch_pkg
`default_nettype wire

// File: rtl/fetch_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : fetch_watchdog
// Description : Counts WAIT cycles that pass without a memory acknowledge
//               and flags the cycle in which the budget of MAX_WAIT cycles
//               is exhausted. The counter saturates and never wraps.
// Ports       : clk, rst  - clock, synchronous active-high reset
//               clr       - restart the count (a new request is being set up)
//               en        - a WAIT cycle without acknowledge is in progress
//               timeout   - this is the last permitted cycle and no ack came
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_watchdog #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    // The count equals the number of completed ack-less WAIT cycles, so the
    // final allowed cycle is the one that starts with MAX_WAIT-1 already seen.
    localparam logic [CW-1:0] c_last_cnt = CW'(MAX_WAIT - 1);
    localparam logic [CW-1:0] c_max_cnt  = CW'(MAX_WAIT);

    logic [CW-1:0] r_wait_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (clr) begin
            r_wait_cnt <= '0;
        end else if (en && (r_wait_cnt != c_max_cnt)) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    assign timeout = en && (r_wait_cnt == c_last_cnt);

endmodule : fetch_watchdog
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch stage. Latches the PC, runs a req/ack
//               transaction on the instruction memory port, holds the
//               fetched word toward decode with a valid/ready handshake and
//               stalls the PC until the word is consumed. Supports redirect
//               flushes and a bounded-wait watchdog that raises a sticky
//               fetch error.
// Config      : IFETCH_ALIGN_CHECK_EN - when defined, a misaligned PC sends
//               the stage to the error state without issuing a request;
//               otherwise the low two address bits are forced to zero.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               pc, flush                - PC input, redirect/flush
//               imem_req/addr/ack/rdata  - instruction memory port
//               inst, inst_pc, inst_valid, inst_ready - decode handshake
//               fetch_stall              - PC must hold while high
//               fetch_err                - sticky error (exit via rst only)
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_LEN-1:0] pc,
    input  logic                flush,
    output logic                imem_req,
    output logic [ADDR_LEN-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [INST_LEN-1:0] imem_rdata,
    output logic [INST_LEN-1:0] inst,
    output logic [ADDR_LEN-1:0] inst_pc,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic                fetch_stall,
    output logic                fetch_err
);

    if_state_e           r_state;
    logic [ADDR_LEN-1:0] r_addr_q;
    logic                r_req;
    logic                r_drop;
    logic [INST_LEN-1:0] r_inst;
    logic [ADDR_LEN-1:0] r_inst_pc;
    logic                r_inst_valid;
    logic                r_err;

    logic w_consume;
    logic w_latch;
    logic w_wd_en;
    logic w_timeout;
    logic w_pc_bad;

    // Decode takes the held word this cycle (flush overrides acceptance).
    assign w_consume = (r_state == IF_HOLD) && inst_ready && !flush;

    // The PC is sampled in IDLE and when the held word is consumed.
    assign w_latch   = (r_state == IF_IDLE) || w_consume;
    assign w_wd_en   = (r_state == IF_WAIT) && !imem_ack;

`ifdef IFETCH_ALIGN_CHECK_EN
    assign w_pc_bad  = !is_word_aligned(pc);
    assign imem_addr = r_addr_q;
`else
    assign w_pc_bad  = 1'b0;
    assign imem_addr = {r_addr_q[ADDR_LEN-1:2], 2'b00};
`endif

    fetch_watchdog #(
        .MAX_WAIT (MAX_WAIT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_latch),
        .en      (w_wd_en),
        .timeout (w_timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IF_IDLE;
            r_addr_q     <= '0;
            r_req        <= 1'b0;
            r_drop       <= 1'b0;
            r_inst       <= INST_RESET;
            r_inst_pc    <= '0;
            r_inst_valid <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                IF_IDLE: begin
                    if (w_pc_bad) begin
                        r_state <= IF_ERR;
                        r_err   <= 1'b1;
                    end else begin
                        r_addr_q <= pc;
                        r_req    <= 1'b1;
                        r_state  <= IF_WAIT;
                    end
                end

                IF_WAIT: begin
                    if (imem_ack) begin
                        r_req  <= 1'b0;
                        r_drop <= 1'b0;
                        if (r_drop || flush) begin
                            // Data belongs to a path that was redirected away.
                            r_state <= IF_IDLE;
                        end else begin
                            r_inst       <= imem_rdata;
                            r_inst_pc    <= r_addr_q;
                            r_inst_valid <= 1'b1;
                            r_state      <= IF_HOLD;
                        end
                    end else begin
                        // The request stays up until acknowledged; a flush
                        // only marks the eventual data for discard.
                        if (flush) begin
                            r_drop <= 1'b1;
                        end
                        if (w_timeout) begin
                            r_req   <= 1'b0;
                            r_err   <= 1'b1;
                            r_state <= IF_ERR;
                        end
                    end
                end

                IF_HOLD: begin
                    if (flush) begin
                        r_inst_valid <= 1'b0;
                        r_state      <= IF_IDLE;
                    end else if (inst_ready) begin
                        r_inst_valid <= 1'b0;
                        if (w_pc_bad) begin
                            r_state <= IF_ERR;
                            r_err   <= 1'b1;
                        end else begin
                            r_addr_q <= pc;
                            r_req    <= 1'b1;
                            r_state  <= IF_WAIT;
                        end
                    end
                end

                IF_ERR: begin
                    r_req        <= 1'b0;
                    r_inst_valid <= 1'b0;
                    r_err        <= 1'b1;
                end

                default: begin
                    r_state <= IF_IDLE;
                end
            endcase
        end
    end

    assign imem_req    = r_req;
    assign inst        = r_inst;
    assign inst_pc     = r_inst_pc;
    assign inst_valid  = r_inst_valid;
    assign fetch_err   = r_err;
    assign fetch_stall = !w_consume;

endmodule : instr_fetch
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Self-checking bench for instr_fetch (MAX_WAIT = 4). Expected
//               instructions are queued as memory responses are issued; a
//               monitor compares each newly presented instruction against
//               the queue. Cycle-level signals are checked inline.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    localparam int TB_MAX_WAIT = 4;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        fetch_stall;
    logic        fetch_err;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    logic prev_valid = 1'b0;

    instr_fetch #(
        .MAX_WAIT (TB_MAX_WAIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .fetch_stall (fetch_stall),
        .fetch_err   (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock; outputs are stable 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] i, input logic [31:0] p);
        exp_t e;
        e.inst = i;
        e.pc   = p;
        exp_q.push_back(e);
    endtask

    // Monitor: each newly presented instruction must match the queue head.
    always @(negedge clk) begin
        if (!rst && inst_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid: got inst 0x%08h pc 0x%08h expected none", inst, inst_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("mon_inst", inst, e.inst);
                check("mon_inst_pc", inst_pc, e.pc);
            end
        end
        prev_valid <= inst_valid;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst        = 1'b1;
        pc         = 32'h0;
        flush      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        inst_ready = 1'b0;
        step();
        step();

        // Reset state
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_fetch_stall", {31'd0, fetch_stall}, 32'd1);
        check("rst_fetch_err", {31'd0, fetch_err}, 32'd0);

        // Zero-wait fetch from pc 0
        rst        = 1'b0;
        inst_ready = 1'b1;
        check("t1_req_cycle1", {31'd0, imem_req}, 32'd0);
        step();
        check("t1_req_cycle2", {31'd0, imem_req}, 32'd1);
        check("t1_addr", imem_addr, 32'h0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h2008_0005;
        push_exp(32'h2008_0005, 32'h0);
        step();
        imem_ack = 1'b0;
        check("t1_valid", {31'd0, inst_valid}, 32'd1);
        check("t1_stall_low", {31'd0, fetch_stall}, 32'd0);
        pc = 32'h4;
        step();
        check("t1_stall_back", {31'd0, fetch_stall}, 32'd1);
        check("t1_valid_drop", {31'd0, inst_valid}, 32'd0);
        check("t1_next_req", {31'd0, imem_req}, 32'd1);
        check("t1_next_addr", imem_addr, 32'h4);

        // Ack in WAIT cycle 3, decode not ready for 4 HOLD cycles
        inst_ready = 1'b0;
        step();
        check("t2_addr_c2", imem_addr, 32'h4);
        check("t2_stall_c2", {31'd0, fetch_stall}, 32'd1);
        step();
        check("t2_addr_c3", imem_addr, 32'h4);
        imem_ack   = 1'b1;
        imem_rdata = 32'h1111_2222;
        push_exp(32'h1111_2222, 32'h4);
        step();
        imem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t2_hold_valid", {31'd0, inst_valid}, 32'd1);
            check("t2_hold_inst", inst, 32'h1111_2222);
            check("t2_hold_pc", inst_pc, 32'h4);
            check("t2_hold_stall", {31'd0, fetch_stall}, 32'd1);
            step();
        end

        // Flush and ready together in HOLD: flush wins
        flush      = 1'b1;
        inst_ready = 1'b1;
        check("t4_stall_flush", {31'd0, fetch_stall}, 32'd1);
        step();
        flush      = 1'b0;
        inst_ready = 1'b0;
        check("t4_valid_cleared", {31'd0, inst_valid}, 32'd0);
        check("t4_idle_no_req", {31'd0, imem_req}, 32'd0);
        pc = 32'h100;
        step();
        check("t3_req", {31'd0, imem_req}, 32'd1);
        check("t3_addr", imem_addr, 32'h100);

        // Flush in WAIT cycle 1, ack in cycle 3: data discarded
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t3_req_held", {31'd0, imem_req}, 32'd1);
        check("t3_addr_held", imem_addr, 32'h100);
        pc = 32'h200;
        step();
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 1'b0;
        check("t3_no_valid", {31'd0, inst_valid}, 32'd0);
        check("t3_idle_no_req", {31'd0, imem_req}, 32'd0);
        step();
        check("t3_new_req", {31'd0, imem_req}, 32'd1);
        check("t3_new_addr", imem_addr, 32'h200);
        imem_ack   = 1'b1;
        imem_rdata = 32'h3333_4444;
        push_exp(32'h3333_4444, 32'h200);
        inst_ready = 1'b1;
        step();
        imem_ack = 1'b0;
        check("t3_valid", {31'd0, inst_valid}, 32'd1);
        pc = 32'h204;
        step();
        inst_ready = 1'b0;

        // No ack: error after the 4th WAIT cycle
        for (int k = 1; k <= TB_MAX_WAIT; k++) begin
            check("t5_no_err_yet", {31'd0, fetch_err}, 32'd0);
            check("t5_req_up", {31'd0, imem_req}, 32'd1);
            step();
        end
        check("t5_err_set", {31'd0, fetch_err}, 32'd1);
        check("t5_err_no_req", {31'd0, imem_req}, 32'd0);
        check("t5_err_stall", {31'd0, fetch_stall}, 32'd1);
        imem_ack = 1'b1;
        step();
        step();
        imem_ack = 1'b0;
        check("t5_err_sticky", {31'd0, fetch_err}, 32'd1);
        check("t5_err_no_valid", {31'd0, inst_valid}, 32'd0);
        rst = 1'b1;
        step();
        check("t5_rst_clears", {31'd0, fetch_err}, 32'd0);
        check("t5_rst_no_req", {31'd0, imem_req}, 32'd0);

        // Misaligned PC
        rst = 1'b0;
        pc  = 32'h6;
        step();
`ifdef IFETCH_ALIGN_CHECK_EN
        check("t6_align_no_req", {31'd0, imem_req}, 32'd0);
        check("t6_align_err", {31'd0, fetch_err}, 32'd1);
`else
        check("t6_noalign_req", {31'd0, imem_req}, 32'd1);
        check("t6_noalign_addr", imem_addr, 32'h4);
        check("t6_noalign_err", {31'd0, fetch_err}, 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h5555_6666;
        push_exp(32'h5555_6666, 32'h6);
        step();
        imem_ack = 1'b0;
        check("t6_valid", {31'd0, inst_valid}, 32'd1);
`endif
        step();
        step();

        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_instr_fetch
`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage directly downstream of the program counter. Latches the current PC, runs a request/acknowledge transaction on the instruction-memory port, and holds the fetched word with a valid/ready handshake toward decode. Drives `fetch_stall` so the PC advances only when an instruction has been consumed. Supports redirect flushes and a bounded-wait watchdog that reports a fetch error.

## Interface
- `MAX_WAIT`, 15: maximum WAIT cycles without `imem_ack` before error; legal range 1..255.
- `clk` input 1: clock, all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `pc` input `ADDR_LEN`: current PC from program_counter.
- `flush` input 1: redirect (jump / taken branch); discard in-flight and held instruction.
- `imem_req` output 1: memory request.
- `imem_addr` output `ADDR_LEN`: request address, stable while `imem_req`=1.
- `imem_ack` input 1: memory ack; `imem_rdata` valid in the same cycle.
- `imem_rdata` input `INST_LEN`: fetched word.
- `inst` output `INST_LEN`: held instruction.
- `inst_pc` output `ADDR_LEN`: address of `inst`.
- `inst_valid` output 1: `inst`/`inst_pc` valid.
- `inst_ready` input 1: decode accepts.
- `fetch_stall` output 1: PC must hold when 1.
- `fetch_err` output 1: sticky fetch error.

## Operation
- States: IDLE, WAIT, HOLD, ERR (encodings in `defines.v`).
- IDLE: `imem_req`=0; latch `pc` into `addr_q`, clear `wait_cnt`, next state WAIT.
- WAIT: `imem_req`=1, `imem_addr`=`addr_q`, `wait_cnt`++ each cycle without ack.
  - `imem_ack` with no drop pending: `inst`<=`imem_rdata`, `inst_pc`<=`addr_q`, go HOLD.
  - `imem_ack` with drop pending, or `flush` in the ack cycle: discard data, clear drop, go IDLE.
  - `flush` without ack: set drop flag; stay WAIT (request is never withdrawn before ack).
  - no ack and `wait_cnt` reaches `MAX_WAIT`: go ERR.
- HOLD: `inst_valid`=1.
  - `flush`: `inst_valid`<=0, go IDLE (flush wins over `inst_ready`).
  - `inst_ready`: latch `pc` into `addr_q` (PC has advanced this edge), clear `wait_cnt`, go WAIT.
  - otherwise hold all outputs.
- ERR: `imem_req`=0, `inst_valid`=0, `fetch_err`=1, `fetch_stall`=1; exits only via `rst`.
- `fetch_stall` = NOT (state==HOLD AND `inst_ready` AND NOT `flush`).
- `rst` in any state, including mid-transaction: next state IDLE. Any outstanding memory transaction is abandoned; the memory side must tolerate this.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=0, `inst`=0, `inst_pc`=0, `inst_valid`=0, `fetch_stall`=1, `fetch_err`=0, `wait_cnt`=0, drop=0.
- First request is issued the 2nd cycle after `rst` deasserts (IDLE then WAIT).
- Ack in the first WAIT cycle gives `inst_valid` the next cycle. Back-to-back throughput is 1 instruction per 2 cycles with zero-wait memory and `inst_ready` held high.
- Ack in WAIT cycle k (1-based) is accepted for k ≤ `MAX_WAIT`. ERR is entered on the edge ending WAIT cycle `MAX_WAIT` if no ack was seen.
- `wait_cnt` width is clog2(`MAX_WAIT`+1) and it never wraps.

## Configuration
- `IFETCH_ALIGN_CHECK_EN` defined: when `pc` is latched (IDLE, or HOLD with `inst_ready`) and `pc[1:0]`≠0, go directly to ERR with no request issued. `fetch_err` is set on the next edge.
- Not defined: `pc[1:0]` is ignored and `imem_addr` is forced to {`addr_q[ADDR_LEN-1:2]`, 2'b00}. No alignment error can occur.

## Structure
- `defines.v`: `ADDR_LEN`, `INST_LEN` (32), the four state encodings (`IF_IDLE`, `IF_WAIT`, `IF_HOLD`, `IF_ERR`, 2 bits), and the reset instruction value.
- One natural sub-module: `fetch_watchdog`. It holds `wait_cnt`, takes clear/enable inputs, and outputs a timeout.

## Test plan
- Reset release, `pc`=0x0000_0000, ack in the 1st WAIT cycle with rdata 0x2008_0005, `inst_ready`=1 → `imem_req` rises in cycle 2; `inst`=0x2008_0005, `inst_pc`=0 and `inst_valid`=1 in cycle 3; `fetch_stall`=0 for that cycle only.
- Ack delayed 3 cycles, `inst_ready` low for 4 HOLD cycles → `imem_addr` stable for 3 cycles; `inst` and `inst_pc` held; `fetch_stall`=1 throughout.
- `flush` in WAIT cycle 1, ack in cycle 3 → rdata discarded, no `inst_valid`, IDLE, then a new request with the new `pc`.
- `flush` and `inst_ready` both high in HOLD → `inst_valid` 0 next cycle, `fetch_stall`=1, IDLE.
- `MAX_WAIT`=4, no ack → `fetch_err`=1 after the 4th WAIT cycle and stays set; `rst` clears it.
- With `IFETCH_ALIGN_CHECK_EN`, `pc`=0x0000_0006 → no `imem_req`, `fetch_err`=1. Without it → `imem_addr`=0x0000_0004.
